// File: rtl/serial_subtractor_disp_pkg.sv
// Shared types and constants for the serial subtractor display block:
// FSM encoding, operand select, and the seven-segment code table.
package sub_disp_pkg;

    localparam logic [1:0] IDLE_ENC   = 2'd0;
    localparam logic [1:0] CALC_ENC   = 2'd1;
    localparam logic [1:0] RESULT_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE_ENC,
        ST_CALC   = CALC_ENC,
        ST_RESULT = RESULT_ENC
    } state_t;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_t;

    localparam int SEG_DP_BIT = 8;

    // Entry 15 first, entry 0 last.
    localparam logic [15:0][8:0] SEG_TABLE = {
        9'h071, 9'h079, 9'h05e, 9'h039, 9'h07c, 9'h077, 9'h06f, 9'h07f,
        9'h007, 9'h07d, 9'h06d, 9'h066, 9'h04f, 9'h05b, 9'h006, 9'h03f
    };

    function automatic logic [8:0] seg_code(input logic [3:0] value);
        logic [8:0] code;
        code             = SEG_TABLE[value];
        code[SEG_DP_BIT] = 1'b0;
        return code;
    endfunction

endpackage

// File: rtl/serial_subtractor_disp_if.sv
// Key, switch and display bundle of the serial subtractor, plus FSM/select
// observation signals.
interface serial_subtractor_disp_if
    import sub_disp_pkg::*;
#(
    parameter int WIDTH = 4
);
    // show/calc are raw active-low keys. busy is high for exactly the WIDTH
    // shift cycles; done pulses for one cycle on the edge that updates
    // diff/borrow, which then hold until the next done or reset.
    logic             show;
    logic             calc;
    logic [WIDTH-1:0] segdata;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             busy;
    logic             done;
    logic [8:0]       segled1;
    logic [8:0]       segled2;
    state_t           state;
    sel_t             sel;

    modport master (
        output show, calc, segdata,
        input  diff, borrow, busy, done, segled1, segled2, state, sel
    );

    modport slave (
        input  show, calc, segdata,
        output diff, borrow, busy, done, segled1, segled2, state, sel
    );

endinterface

// File: rtl/serial_subtractor_disp_key_debounce.sv
// Raw active-low key to one-cycle press pulse: 2-flop synchroniser, stable-level
// debounce counter, and falling-edge detect on the debounced level.
module key_debounce #(
    parameter int DB_CNT = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse
);
    localparam int              CW       = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CNT - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Synchroniser preset to the released level so leaving reset never
            // looks like a press, whatever DB_CNT is.
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            level   <= 1'b1;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync_q1 <= key;
            sync_q2 <= sync_q1;
            pulse   <= 1'b0;
            if (sync_q2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_q2;
                    cnt   <= '0;
                    pulse <= ~sync_q2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/serial_subtractor_disp.sv
// Bit-serial A - B calculator with key entry and two seven-segment displays
// (borrow on display 1, difference on display 2).
module serial_subtractor_disp
    import sub_disp_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DB_CNT = 500000
) (
    input logic                     clk,
    input logic                     rst,
    serial_subtractor_disp_if.slave io
);
    localparam int              CNTW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    sel_t             sel;
    logic             show_pulse;
    logic             calc_pulse;
    logic             start;
    logic             last_bit;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] diff_q;
    logic             br;
    logic             br_nxt;
    logic             d;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;
    logic [CNTW-1:0]  bit_cnt;
    logic [8:0]       seg1;
    logic [8:0]       seg2;

    key_debounce #(.DB_CNT(DB_CNT)) u_show_key (
        .clk   (clk),
        .rst   (rst),
        .key   (io.show),
        .pulse (show_pulse)
    );

    key_debounce #(.DB_CNT(DB_CNT)) u_calc_key (
        .clk   (clk),
        .rst   (rst),
        .key   (io.calc),
        .pulse (calc_pulse)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // show has priority over calc; both keys are ignored while shifting.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (calc_pulse && !show_pulse) begin
                    start     = 1'b1;
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (last_bit) begin
                    state_nxt = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (show_pulse) begin
                    state_nxt = ST_IDLE;
                end else if (calc_pulse) begin
                    start     = 1'b1;
                    state_nxt = ST_CALC;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign last_bit = (bit_cnt == LAST_BIT);
    assign d        = sa[0] ^ sb[0] ^ br;
    assign br_nxt   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign res_nxt  = (res >> 1) | (WIDTH'(d) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel      <= SEL_A;
            op_a     <= '0;
            op_b     <= '0;
            sa       <= '0;
            sb       <= '0;
            res      <= '0;
            br       <= 1'b0;
            bit_cnt  <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (show_pulse) begin
                if (state == ST_IDLE) begin
                    if (sel == SEL_A) begin
                        op_a <= io.segdata;
                    end else begin
                        op_b <= io.segdata;
                    end
                    sel <= (sel == SEL_A) ? SEL_B : SEL_A;
                end else if (state == ST_RESULT) begin
                    op_a <= io.segdata;
                    sel  <= SEL_B;
                end
            end
            if (start) begin
                sa      <= op_a;
                sb      <= op_b;
                br      <= 1'b0;
                bit_cnt <= '0;
                busy_q  <= 1'b1;
            end
            if (state == ST_CALC) begin
                sa      <= sa >> 1;
                sb      <= sb >> 1;
                res     <= res_nxt;
                br      <= br_nxt;
                bit_cnt <= bit_cnt + 1'b1;
                if (last_bit) begin
                    diff_q   <= res_nxt;
                    borrow_q <= br_nxt;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        if (state == ST_RESULT) begin
            seg1 = seg_code(4'(borrow_q));
            seg2 = seg_code(4'(diff_q));
        end else begin
            seg1 = seg_code(4'(op_a));
            seg2 = seg_code(4'(op_b));
        end
    end

    assign io.diff    = diff_q;
    assign io.borrow  = borrow_q;
    assign io.busy    = busy_q;
    assign io.done    = done_q;
    assign io.segled1 = seg1;
    assign io.segled2 = seg2;
    assign io.state   = state;
    assign io.sel     = sel;

endmodule
